pcs_tx_gearbox: RTL and testbench

//  TX 66b->32b gearbox directly downstream of the PCS encoder/scrambler.

---
 rtl/pcs_pkg.sv | 9 +
 rtl/pcs_gearbox_shift.sv | 23 ++
 rtl/pcs_tx_gearbox.sv | 96 +++++++++
 tb/tb_pcs_tx_gearbox.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared PCS constants: sync header encodings and TX gearbox sequencing.
package pcs_pkg;
  localparam int HEAD_W          = 2;
  localparam int GEARBOX_DATA_W  = 32;
  localparam int GEARBOX_SEQ_MAX = 32;

  localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b01;
  localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b10;
endpackage

// File: rtl/pcs_gearbox_shift.sv
// Merge stage: keeps the low fill_i residual bits of buf_i and appends in_i
// directly above them, LSB-first.
module pcs_gearbox_shift
  import pcs_pkg::*;
#(
  parameter int BUF_W  = 2 * GEARBOX_DATA_W,
  parameter int IN_W   = GEARBOX_DATA_W + HEAD_W,
  parameter int FILL_W = 6
) (
  input  logic [BUF_W-1:0]  buf_i,
  input  logic [FILL_W-1:0] fill_i,
  input  logic [IN_W-1:0]   in_i,
  output logic [BUF_W-1:0]  cat_o
);

  logic [BUF_W-1:0] mask;

  always_comb begin
    mask  = (BUF_W'(1) << fill_i) - BUF_W'(1);
    cat_o = (buf_i & mask) | (BUF_W'(in_i) << fill_i);
  end

endmodule

// File: rtl/pcs_tx_gearbox.sv
// TX 66b->32b gearbox: packs sync header + payload halves into a continuous
// 32-bit line stream, stalling upstream once every SEQ_MAX+1 cycles.
module pcs_tx_gearbox
  import pcs_pkg::*;
#(
  parameter int DATA_W  = GEARBOX_DATA_W,
  parameter int SEQ_MAX = GEARBOX_SEQ_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              head_v_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              data_v_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);

  localparam int IN_W   = DATA_W + HEAD_W;
  localparam int BUF_W  = 2 * DATA_W;
  localparam int FILL_W = $clog2(DATA_W + 1);
  localparam int SEQ_W  = $clog2(SEQ_MAX + 1);

  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_v_q, data_v_d;
  logic              err_q, err_d;

  logic              stall;
  logic [IN_W-1:0]   in_bits;
  logic [BUF_W-1:0]  cat;

  assign stall   = (seq_q == SEQ_W'(SEQ_MAX));
  assign ready_o = !stall;
  assign in_bits = head_v_i ? {data_i, head_i} : IN_W'(data_i);

  pcs_gearbox_shift #(
    .BUF_W (BUF_W),
    .IN_W  (IN_W),
    .FILL_W(FILL_W)
  ) u_shift (
    .buf_i (buf_q),
    .fill_i(fill_q),
    .in_i  (in_bits),
    .cat_o (cat)
  );

  always_comb begin
    seq_d    = seq_q + SEQ_W'(1);
    fill_d   = fill_q;
    buf_d    = buf_q;
    data_d   = data_q;
    data_v_d = 1'b1;
    err_d    = err_q;
    if (stall) begin
      // Accumulated headers have built exactly one extra word; drain it.
      seq_d  = '0;
      data_d = buf_q[DATA_W-1:0];
      buf_d  = '0;
      fill_d = '0;
      if (fill_q != FILL_W'(DATA_W)) err_d = 1'b1;
    end else begin
      data_d = cat[DATA_W-1:0];
      buf_d  = cat >> DATA_W;
      if (head_v_i) fill_d = fill_q + FILL_W'(HEAD_W);
      // Headers belong on even sequence slots only.
      if (head_v_i == seq_q[0]) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q    <= '0;
      fill_q   <= '0;
      buf_q    <= '0;
      data_q   <= '0;
      data_v_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      seq_q    <= seq_d;
      fill_q   <= fill_d;
      buf_q    <= buf_d;
      data_q   <= data_d;
      data_v_q <= data_v_d;
      err_q    <= err_d;
    end
  end

  assign data_o   = data_q;
  assign data_v_o = data_v_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// Scoreboard bench for pcs_tx_gearbox: a bit-serial reference stream is
// compared 32 bits at a time against the line output.
module tb_pcs_tx_gearbox;
  import pcs_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        head_v_i;
  logic [1:0]  head_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        data_v_o;
  logic [31:0] data_o;
  logic        err_o;

  pcs_tx_gearbox dut (
    .clk     (clk),
    .reset   (reset),
    .head_v_i(head_v_i),
    .head_i  (head_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .data_v_o(data_v_o),
    .data_o  (data_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int seq_m = 0;
  int n_words = 0;
  int max_fill = 0;
  bit sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, push accepted bits, then score the output word.
  task automatic step(input logic hv, input logic [1:0] h, input logic [31:0] d);
    logic [31:0] w;
    head_v_i = hv; head_i = h; data_i = d;
    chk("ready", ready_o, seq_m != 32);
    if (seq_m != 32) begin
      if (hv) begin sb.push_back(h[0]); sb.push_back(h[1]); end
      for (int i = 0; i < 32; i++) sb.push_back(d[i]);
    end
    @(posedge clk); #1;
    seq_m = (seq_m == 32) ? 0 : seq_m + 1;
    if (int'(dut.fill_q) > max_fill) max_fill = int'(dut.fill_q);
    chk("data_v", data_v_o, 1'b1);
    if (sb.size() >= 32) begin
      for (int i = 0; i < 32; i++) w[i] = sb.pop_front();
      n_words++;
      chk("data", data_o, w);
    end
  endtask

  task automatic stall_if_due();
    if (seq_m == 32) step(1'($urandom_range(0, 1)), 2'($urandom), $urandom);
  endtask

  task automatic send_block(input logic [1:0] h, input logic [31:0] d0, input logic [31:0] d1);
    stall_if_due();
    step(1'b1, h, d0);
    step(1'b0, 2'b00, d1);
  endtask

  task automatic do_reset();
    reset = 1'b1; head_v_i = 1'b0; head_i = '0; data_i = '0;
    @(posedge clk); #1;
    chk("rst_data", data_o, 32'h0);
    chk("rst_vld", data_v_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_fill", dut.fill_q, 0);
    reset = 1'b0;
    seq_m = 0;
    sb.delete();
  endtask

  task automatic scen1();
    logic [31:0] exp_w;
    exp_w = {30'h2AAAAAAA, 2'b10};
    step(1'b1, SYNC_CTRL, 32'hAAAAAAAA);
    chk("s1_first", data_o, exp_w);
    step(1'b0, 2'b00, 32'h55555555);
    chk("s1_err", err_o, 1'b0);
  endtask

  initial begin
    int w0;
    reset = 1'b1; head_v_i = 1'b0; head_i = '0; data_i = '0;
    repeat (2) @(posedge clk);

    // 1: single control block
    do_reset();
    scen1();

    // 2: 16 data blocks plus the stall word -> exactly 33 words
    do_reset();
    w0 = n_words;
    for (int b = 0; b < 16; b++) send_block(SYNC_DATA, 32'h1000 + 2 * b, 32'h1001 + 2 * b);
    chk("s2_seq32", ready_o, 1'b0);
    stall_if_due();
    chk("s2_words", n_words - w0, 33);
    chk("s2_residue", sb.size(), 0);
    chk("s2_err", err_o, 1'b0);

    // 3: random blocks (stall cycles carry junk inputs, covering 6 too)
    do_reset();
    max_fill = 0;
    for (int b = 0; b < 1000; b++)
      send_block($urandom_range(0, 1) ? SYNC_DATA : SYNC_CTRL, $urandom, $urandom);
    chk("s3_err", err_o, 1'b0);
    chk("s3_maxfill", max_fill, 32);

    // 4: header on odd slot -> sticky error until reset
    do_reset();
    step(1'b1, SYNC_DATA, 32'h12345678);
    chk("s4_pre", err_o, 1'b0);
    step(1'b1, SYNC_DATA, 32'h9ABCDEF0);
    chk("s4_set", err_o, 1'b1);
    step(1'b0, 2'b00, 32'h0);
    step(1'b1, SYNC_DATA, 32'h0);
    chk("s4_sticky", err_o, 1'b1);
    do_reset();
    chk("s4_clear", err_o, 1'b0);

    // 5: reset mid-period at seq 17, fill 18
    for (int b = 0; b < 8; b++) send_block(SYNC_DATA, $urandom, $urandom);
    step(1'b1, SYNC_CTRL, $urandom);
    chk("s5_seq", dut.seq_q, 17);
    chk("s5_fill", dut.fill_q, 18);
    do_reset();
    chk("s5_seq0", dut.seq_q, 0);
    scen1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
